multi_rect_object: RTL and testbench
====================================

Name: multi_rect_object

Overview:
- Parametrised successor of the single-rectangle drawer.
- Draws up to NUM_OBJ independently configured rectangles. Each has its own position, width, height, colour, enable and blink mode.
- Configuration is written through a load handshake into shadow registers. Shadow registers commit to live registers only at start of frame, so there is no mid-frame tearing.
- Sits between game-logic controllers and the VGA object mux. Outputs a registered drawing request, offsets and the index of the winning object.

Parameters:
- NUM_OBJ, 4, number of rectangle channels (1..16).
- COORD_W, 11, signed width of pixel and position coordinates.
- DIM_W, 11, unsigned width of width/height fields.
- BLINK_FRAMES, 16, frames per blink half-period (>=1).
- IDX_W, $clog2(NUM_OBJ) (min 1), index width, derived.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pixelX  in  COORD_W signed  current VGA pixel X.
- pixelY  in  COORD_W signed  current VGA pixel Y.
- startOfFrame  in  1  one-cycle pulse at frame start.
- load_valid  in  1  config write request.
- load_ready  out  1  config write accepted when valid&ready.
- load_idx  in  IDX_W  target channel.
- load_topLeftX  in  COORD_W signed  top-left X; may be negative.
- load_topLeftY  in  COORD_W signed  top-left Y; may be negative.
- load_width  in  DIM_W  width in pixels.
- load_height  in  DIM_W  height in pixels.
- load_color  in  8  RGB332 colour.
- load_enable  in  1  channel visible.
- load_blink  in  1  channel blinks.
- drawingRequest  out  1  pixel is inside a visible rectangle.
- objectIdx  out  IDX_W  winning channel.
- offsetX  out  COORD_W  pixelX minus winner topLeftX.
- offsetY  out  COORD_W  pixelY minus winner topLeftY.
- RGBout  out  8  winner colour, else 8'hFF (transparent).

Behaviour:
- Reset (synchronous, active-high): all shadow and live configs cleared, so enable=0 and width=height=0. Blink counter=0, blinkPhase=1 (visible). Pipeline registers cleared. Outputs: drawingRequest=0, objectIdx=0, offsetX=0, offsetY=0, RGBout=8'hFF, load_ready=0 during reset and 1 afterwards.
- Load handshake:
  - load_ready = !reset && !startOfFrame.
  - On valid&ready, shadow[load_idx] takes all load_* fields.
  - load_idx >= NUM_OBJ: accepted and ignored.
  - Repeated loads to the same index before commit: last one wins.
- Commit: in a cycle with startOfFrame=1, live <= shadow for all channels, and no load is accepted that cycle.
- Blink:
  - Counter increments on each startOfFrame.
  - When the counter reaches BLINK_FRAMES-1 it wraps to 0 and blinkPhase toggles.
  - A channel is visible iff enable && (!blink || blinkPhase).
- Hit test, stage 1, registered:
  - hit[i] = visible[i] && pixelX>=X && pixelX<X+W && pixelY>=Y && pixelY<Y+H.
  - Arithmetic is signed at COORD_W+1 bits, with width/height zero-extended, so there is no overflow at the screen edge.
  - W=0 or H=0: never hits.
  - Per-channel offsets are registered alongside the hit bits.
- Priority, stage 2, registered: the lowest hit index wins. Its offsets, colour and index are output, and drawingRequest=1.
- No hit: drawingRequest=0, RGBout=8'hFF, offsets=0, objectIdx=0.
- Latency: pixel in cycle N appears at outputs in cycle N+2, fixed and independent of NUM_OBJ.
- Reset mid-frame: pipeline flushed, and outputs hold reset values from the next edge.

Decomposition:
- Package multi_rect_pkg holds:
  - obj_cfg_t packed struct {topLeftX, topLeftY, width, height, color, enable, blink}.
  - TRANSPARENT_ENCODING = 8'hFF.
- Sub-module rect_hit_unit, one per channel via generate. It takes the live cfg, the pixel and blinkPhase, and produces the registered hit bit plus offsetX/offsetY (stage 1).
- Top level holds the shadow/live registers, blink counter, handshake and stage-2 priority select.

Test Plan:
- Load ch0 {X=100,Y=50,W=20,H=10,color=8'h1C,en=1}, then startOfFrame. Pixel (100,50) gives drawingRequest=1, RGBout=8'h1C, offset (0,0) two cycles later. Pixels (120,50) and (100,60) give drawingRequest=0, RGBout=8'hFF.
- Overlap: ch0 and ch2 both cover (30,30), ch2 color 8'hE0. Pixel (30,30) gives objectIdx=0 with ch0 colour. Disable ch0 and commit: objectIdx=2, RGBout=8'hE0.
- Negative position: ch1 {X=-5,Y=-3,W=10,H=10}. Pixel (0,0) gives hit with offset (5,3). Pixel (5,0) gives no hit.
- Tear-free update: load new X mid-frame. Output keeps the old position until after the next startOfFrame. A load held valid during the startOfFrame cycle sees load_ready=0 and is accepted the next cycle.
- Blink with BLINK_FRAMES=2 and ch0 blink=1. Visible frames 0-1, invisible frames 2-3, visible frames 4-5. A non-blinking channel stays visible throughout.
- Assert reset mid-frame while hitting: next cycle drawingRequest=0 and RGBout=8'hFF. After a commit, all channels are disabled until reloaded.

Source files
------------

// File: rtl/multi_rect_pkg.sv
// Shared types and constants for the multi-rectangle object drawer.
package multi_rect_pkg;

  localparam int CFG_COORD_W = 11;
  localparam int CFG_DIM_W   = 11;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  typedef struct packed {
    logic signed [CFG_COORD_W-1:0] topLeftX;
    logic signed [CFG_COORD_W-1:0] topLeftY;
    logic [CFG_DIM_W-1:0]          width;
    logic [CFG_DIM_W-1:0]          height;
    logic [7:0]                    color;
    logic                          enable;
    logic                          blink;
  } obj_cfg_t;

  // Index/counter width with a floor of one bit so single-entry cases still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_rect_object_hit.sv
// Stage 1 of the drawer: per-channel visibility, bounds test and offset capture.
module rect_hit_unit
  import multi_rect_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  obj_cfg_t                      cfg,
  input  logic signed [CFG_COORD_W-1:0] pixel_x,
  input  logic signed [CFG_COORD_W-1:0] pixel_y,
  input  logic                          blink_phase,
  output logic                          hit_q,
  output logic [CFG_COORD_W-1:0]        offset_x_q,
  output logic [CFG_COORD_W-1:0]        offset_y_q,
  output logic [7:0]                    color_q
);

  localparam int EXT_W = CFG_COORD_W + 1;

  logic signed [EXT_W-1:0] px_e, py_e;
  logic signed [EXT_W-1:0] x_lo, y_lo, x_hi, y_hi;
  logic signed [EXT_W-1:0] w_e, h_e;
  logic                    visible, in_x, in_y;
  logic                    hit_d;
  logic [CFG_COORD_W-1:0]  offset_x_d, offset_y_d;
  logic [7:0]              color_d;

  // One guard bit keeps pos+size from wrapping when a rectangle hangs off the screen edge.
  always_comb begin
    px_e       = {pixel_x[CFG_COORD_W-1], pixel_x};
    py_e       = {pixel_y[CFG_COORD_W-1], pixel_y};
    x_lo       = {cfg.topLeftX[CFG_COORD_W-1], cfg.topLeftX};
    y_lo       = {cfg.topLeftY[CFG_COORD_W-1], cfg.topLeftY};
    w_e        = EXT_W'(cfg.width);
    h_e        = EXT_W'(cfg.height);
    x_hi       = x_lo + w_e;
    y_hi       = y_lo + h_e;
    in_x       = (px_e >= x_lo) && (px_e < x_hi);
    in_y       = (py_e >= y_lo) && (py_e < y_hi);
    visible    = cfg.enable && (!cfg.blink || blink_phase);
    hit_d      = visible && in_x && in_y;
    offset_x_d = pixel_x - cfg.topLeftX;
    offset_y_d = pixel_y - cfg.topLeftY;
    color_d    = cfg.color;
  end

  // Colour travels with the hit so a commit between stages cannot pair it with stale geometry.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q      <= 1'b0;
      offset_x_q <= '0;
      offset_y_q <= '0;
      color_q    <= TRANSPARENT_ENCODING;
    end else begin
      hit_q      <= hit_d;
      offset_x_q <= offset_x_d;
      offset_y_q <= offset_y_d;
      color_q    <= color_d;
    end
  end

endmodule

// File: rtl/multi_rect_object.sv
// Multi-channel rectangle drawer: shadow/live config, frame-locked blink, two-stage hit pipeline.
module multi_rect_object
  import multi_rect_pkg::*;
#(
  parameter int NUM_OBJ      = 4,
  parameter int COORD_W      = CFG_COORD_W,
  parameter int DIM_W        = CFG_DIM_W,
  parameter int BLINK_FRAMES = 16,
  parameter int IDX_W        = idx_width(NUM_OBJ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [COORD_W-1:0] pixelX,
  input  logic signed [COORD_W-1:0] pixelY,
  input  logic                      startOfFrame,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [IDX_W-1:0]          load_idx,
  input  logic signed [COORD_W-1:0] load_topLeftX,
  input  logic signed [COORD_W-1:0] load_topLeftY,
  input  logic [DIM_W-1:0]          load_width,
  input  logic [DIM_W-1:0]          load_height,
  input  logic [7:0]                load_color,
  input  logic                      load_enable,
  input  logic                      load_blink,
  output logic                      drawingRequest,
  output logic [IDX_W-1:0]          objectIdx,
  output logic [COORD_W-1:0]        offsetX,
  output logic [COORD_W-1:0]        offsetY,
  output logic [7:0]                RGBout
);

  localparam int               CNT_W    = idx_width(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  obj_cfg_t shadow_q [NUM_OBJ];
  obj_cfg_t shadow_d [NUM_OBJ];
  obj_cfg_t live_q   [NUM_OBJ];
  obj_cfg_t live_d   [NUM_OBJ];

  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  logic     load_fire;
  obj_cfg_t load_cfg;

  assign load_ready = !reset && !startOfFrame;
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    load_cfg          = '0;
    load_cfg.topLeftX = load_topLeftX;
    load_cfg.topLeftY = load_topLeftY;
    load_cfg.width    = load_width;
    load_cfg.height   = load_height;
    load_cfg.color    = load_color;
    load_cfg.enable   = load_enable;
    load_cfg.blink    = load_blink;
  end

  // Out-of-range indices match no channel, so those writes are consumed and dropped.
  always_comb begin
    shadow_d      = shadow_q;
    live_d        = live_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (startOfFrame) begin
      live_d = shadow_q;
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (load_fire && (int'(load_idx) == i)) begin
        shadow_d[i] = load_cfg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      shadow_q      <= shadow_d;
      live_q        <= live_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  logic [NUM_OBJ-1:0] hit_s1;
  logic [COORD_W-1:0] off_x_s1 [NUM_OBJ];
  logic [COORD_W-1:0] off_y_s1 [NUM_OBJ];
  logic [7:0]         color_s1 [NUM_OBJ];

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
    rect_hit_unit u_hit (
      .clk         (clk),
      .reset       (reset),
      .cfg         (live_q[g]),
      .pixel_x     (pixelX),
      .pixel_y     (pixelY),
      .blink_phase (blink_phase_q),
      .hit_q       (hit_s1[g]),
      .offset_x_q  (off_x_s1[g]),
      .offset_y_q  (off_y_s1[g]),
      .color_q     (color_s1[g])
    );
  end

  logic               draw_req_q, draw_req_d;
  logic [IDX_W-1:0]   obj_idx_q, obj_idx_d;
  logic [COORD_W-1:0] offset_x_q, offset_x_d;
  logic [COORD_W-1:0] offset_y_q, offset_y_d;
  logic [7:0]         rgb_q, rgb_d;

  // Scanning from the top index down leaves the lowest hitting channel as the winner.
  always_comb begin
    draw_req_d = 1'b0;
    obj_idx_d  = '0;
    offset_x_d = '0;
    offset_y_d = '0;
    rgb_d      = TRANSPARENT_ENCODING;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        draw_req_d = 1'b1;
        obj_idx_d  = IDX_W'(i);
        offset_x_d = off_x_s1[i];
        offset_y_d = off_y_s1[i];
        rgb_d      = color_s1[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      draw_req_q <= 1'b0;
      obj_idx_q  <= '0;
      offset_x_q <= '0;
      offset_y_q <= '0;
      rgb_q      <= TRANSPARENT_ENCODING;
    end else begin
      draw_req_q <= draw_req_d;
      obj_idx_q  <= obj_idx_d;
      offset_x_q <= offset_x_d;
      offset_y_q <= offset_y_d;
      rgb_q      <= rgb_d;
    end
  end

  assign drawingRequest = draw_req_q;
  assign objectIdx      = obj_idx_q;
  assign offsetX        = offset_x_q;
  assign offsetY        = offset_y_q;
  assign RGBout         = rgb_q;

endmodule

// File: tb/tb_multi_rect_object.sv
// Bench for multi_rect_object: directed scenarios plus random traffic against a frame-level model.
module tb_multi_rect_object;

  localparam int NUM_OBJ = 3;
  localparam int COORD_W = 11;
  localparam int DIM_W   = 11;
  localparam int BF      = 2;
  localparam int IDX_W   = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic signed [COORD_W-1:0] pixelX, pixelY;
  logic                      startOfFrame;
  logic                      load_valid;
  logic                      load_ready;
  logic [IDX_W-1:0]          load_idx;
  logic signed [COORD_W-1:0] load_topLeftX, load_topLeftY;
  logic [DIM_W-1:0]          load_width, load_height;
  logic [7:0]                load_color;
  logic                      load_enable, load_blink;
  logic                      drawingRequest;
  logic [IDX_W-1:0]          objectIdx;
  logic [COORD_W-1:0]        offsetX, offsetY;
  logic [7:0]                RGBout;

  always #5 clk = ~clk;

  multi_rect_object #(
    .NUM_OBJ(NUM_OBJ), .COORD_W(COORD_W), .DIM_W(DIM_W),
    .BLINK_FRAMES(BF), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .load_valid(load_valid), .load_ready(load_ready),
    .load_idx(load_idx), .load_topLeftX(load_topLeftX), .load_topLeftY(load_topLeftY),
    .load_width(load_width), .load_height(load_height), .load_color(load_color),
    .load_enable(load_enable), .load_blink(load_blink),
    .drawingRequest(drawingRequest), .objectIdx(objectIdx),
    .offsetX(offsetX), .offsetY(offsetY), .RGBout(RGBout)
  );

  typedef struct { int x; int y; int w; int h; int color; bit en; bit blink; } mcfg_t;
  typedef struct { bit req; int idx; int ox; int oy; int rgb; } mres_t;

  mcfg_t sh [NUM_OBJ];
  mcfg_t lv [NUM_OBJ];
  int    sof_count;
  mres_t s1, s2;
  int    n_assert = 0;
  int    n_fail   = 0;
  bit    vis_tab [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  function automatic mres_t no_hit();
    mres_t r;
    r.req = 0; r.idx = 0; r.ox = 0; r.oy = 0; r.rgb = 'hFF;
    return r;
  endfunction

  function automatic mcfg_t zero_cfg();
    mcfg_t c;
    c.x = 0; c.y = 0; c.w = 0; c.h = 0; c.color = 0; c.en = 0; c.blink = 0;
    return c;
  endfunction

  // Blink phase flips every BF frames since reset; lowest-numbered covering channel wins.
  function automatic mres_t ref_pixel(int px, int py);
    mres_t r;
    bit    phase_on;
    r = no_hit();
    phase_on = ((sof_count / BF) % 2) == 0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!r.req && lv[i].en && (!lv[i].blink || phase_on) &&
          px >= lv[i].x && px < lv[i].x + lv[i].w &&
          py >= lv[i].y && py < lv[i].y + lv[i].h) begin
        r.req = 1; r.idx = i;
        r.ox = (px - lv[i].x) & 'h7FF;
        r.oy = (py - lv[i].y) & 'h7FF;
        r.rgb = lv[i].color;
      end
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    mres_t r;
    int    k;
    #1;
    chk("load_ready", 32'(load_ready), 32'(!reset && !startOfFrame));
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh[i] = zero_cfg();
        lv[i] = zero_cfg();
      end
      sof_count = 0;
      s1 = no_hit();
      s2 = no_hit();
    end else begin
      r  = ref_pixel(int'(pixelX), int'(pixelY));
      s2 = s1;
      s1 = r;
      if (startOfFrame) begin
        lv = sh;
        sof_count++;
      end else if (load_valid) begin
        k = int'(load_idx);
        if (k < NUM_OBJ) begin
          sh[k].x = int'(load_topLeftX);
          sh[k].y = int'(load_topLeftY);
          sh[k].w = int'(load_width);
          sh[k].h = int'(load_height);
          sh[k].color = int'(load_color);
          sh[k].en = load_enable;
          sh[k].blink = load_blink;
        end
      end
    end
    #1;
    chk("model_req", 32'(drawingRequest), 32'(s2.req));
    chk("model_idx", 32'(objectIdx), 32'(s2.idx));
    chk("model_offx", 32'(offsetX), 32'(s2.ox));
    chk("model_offy", 32'(offsetY), 32'(s2.oy));
    chk("model_rgb", 32'(RGBout), 32'(s2.rgb));
  endtask

  task automatic set_load(int idx, int x, int y, int w, int h, int color, bit en, bit blink);
    load_idx = IDX_W'(idx);
    load_topLeftX = COORD_W'(x);
    load_topLeftY = COORD_W'(y);
    load_width = DIM_W'(w);
    load_height = DIM_W'(h);
    load_color = 8'(color);
    load_enable = en;
    load_blink = blink;
  endtask

  task automatic do_load(int idx, int x, int y, int w, int h, int color, bit en, bit blink);
    set_load(idx, x, y, w, h, color, en, blink);
    load_valid = 1'b1;
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic do_sof();
    startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
  endtask

  task automatic show(int x, int y);
    pixelX = COORD_W'(x);
    pixelY = COORD_W'(y);
    cyc();
    cyc();
  endtask

  task automatic expect_out(string tag, bit req, int idx, int ox, int oy, int rgb);
    chk({tag, "_req"}, 32'(drawingRequest), 32'(req));
    chk({tag, "_idx"}, 32'(objectIdx), 32'(idx));
    chk({tag, "_offx"}, 32'(offsetX), 32'(ox & 'h7FF));
    chk({tag, "_offy"}, 32'(offsetY), 32'(oy & 'h7FF));
    chk({tag, "_rgb"}, 32'(RGBout), 32'(rgb));
  endtask

  initial begin
    int a;
    reset = 1'b1; startOfFrame = 1'b0; load_valid = 1'b0;
    pixelX = '0; pixelY = '0;
    set_load(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_OBJ; i++) begin
      sh[i] = zero_cfg();
      lv[i] = zero_cfg();
    end
    sof_count = 0;
    s1 = no_hit();
    s2 = no_hit();

    cyc(); cyc();
    expect_out("reset", 0, 0, 0, 0, 'hFF);
    reset = 1'b0;
    cyc();

    // single rectangle, edges exclusive on the right/bottom
    do_load(0, 100, 50, 20, 10, 'h1C, 1'b1, 1'b0);
    do_sof();
    show(100, 50);  expect_out("basic_hit", 1, 0, 0, 0, 'h1C);
    show(119, 59);  expect_out("basic_corner", 1, 0, 19, 9, 'h1C);
    show(120, 50);  expect_out("basic_right", 0, 0, 0, 0, 'hFF);
    show(100, 60);  expect_out("basic_bottom", 0, 0, 0, 0, 'hFF);

    // overlap priority
    do_load(0, 20, 20, 20, 20, 'h1C, 1'b1, 1'b0);
    do_load(2, 25, 25, 10, 10, 'hE0, 1'b1, 1'b0);
    do_sof();
    show(30, 30);   expect_out("overlap_low", 1, 0, 10, 10, 'h1C);
    do_load(0, 20, 20, 20, 20, 'h1C, 1'b0, 1'b0);
    do_sof();
    show(30, 30);   expect_out("overlap_ch2", 1, 2, 5, 5, 'hE0);

    // negative position
    do_load(1, -5, -3, 10, 10, 'h03, 1'b1, 1'b0);
    do_sof();
    show(0, 0);     expect_out("neg_hit", 1, 1, 5, 3, 'h03);
    show(5, 0);     expect_out("neg_miss", 0, 0, 0, 0, 'hFF);

    // out-of-range index is swallowed
    do_load(3, 0, 0, 100, 100, 'h55, 1'b1, 1'b0);
    do_sof();
    show(50, 50);   expect_out("oor_idx", 0, 0, 0, 0, 'hFF);

    // tear-free update
    do_load(2, 200, 25, 10, 10, 'hE0, 1'b1, 1'b0);
    show(30, 30);   expect_out("tear_old", 1, 2, 5, 5, 'hE0);
    do_sof();
    show(30, 30);   expect_out("tear_gone", 0, 0, 0, 0, 'hFF);
    show(205, 30);  expect_out("tear_new", 1, 2, 5, 5, 'hE0);
    set_load(2, 25, 25, 10, 10, 'hE0, 1'b1, 1'b0);
    load_valid = 1'b1; startOfFrame = 1'b1;
    cyc();
    startOfFrame = 1'b0;
    cyc();
    load_valid = 1'b0;
    show(30, 30);   expect_out("held_pending", 0, 0, 0, 0, 'hFF);
    do_sof();
    show(30, 30);   expect_out("held_commit", 1, 2, 5, 5, 'hE0);

    // reset while hitting
    reset = 1'b1;
    cyc();
    expect_out("midrst", 0, 0, 0, 0, 'hFF);
    reset = 1'b0;
    do_sof();
    show(30, 30);   expect_out("post_rst_a", 0, 0, 0, 0, 'hFF);
    show(0, 0);     expect_out("post_rst_b", 0, 0, 0, 0, 'hFF);

    // blink from a fresh reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    do_load(0, 10, 10, 5, 5, 'h1C, 1'b1, 1'b1);
    do_load(1, 100, 100, 5, 5, 'h03, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      do_sof();
      show(12, 12);
      chk("blink_ch0", 32'(drawingRequest), 32'(vis_tab[k]));
      show(101, 101);
      chk("steady_ch1", 32'(drawingRequest), 32'd1);
    end

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      a = int'($urandom_range(0, 99));
      reset = (a == 0);
      startOfFrame = (a >= 1 && a < 12);
      load_valid = (a >= 10 && a < 45);
      set_load(int'($urandom_range(0, 3)),
               int'($urandom_range(0, 600)) - 150, int'($urandom_range(0, 600)) - 150,
               int'($urandom_range(0, 400)), int'($urandom_range(0, 400)),
               int'($urandom_range(0, 255)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
      pixelX = COORD_W'(int'($urandom_range(0, 700)) - 100);
      pixelY = COORD_W'(int'($urandom_range(0, 700)) - 100);
      cyc();
    end
    reset = 1'b0; startOfFrame = 1'b0; load_valid = 1'b0;
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
